// File: rtl/adj_readout_if.sv
// Bundles the ADJ memory read port with the valid/ready row output stream of adj_readout_fsm.
// master = readout controller side, slave = memory/downstream side.
interface adj_readout_if #(
    parameter int NUM_OF_NODES    = 6,
    parameter int NUM_OF_FEATURES = 3,
    parameter int FEATURE_WIDTH   = 16,
    parameter int ADDRESS_WIDTH   = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1
);
    logic                                     adj_read_en;
    logic [ADDRESS_WIDTH-1:0]                 adj_read_addr;
    logic [NUM_OF_FEATURES*FEATURE_WIDTH-1:0] adj_read_data;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [NUM_OF_FEATURES*FEATURE_WIDTH-1:0] out_data;
    logic [ADDRESS_WIDTH-1:0]                 out_node_index;
    logic                                     out_last;

    modport master (
        output adj_read_en, adj_read_addr,
        input  adj_read_data,
        output out_valid, out_data, out_node_index, out_last,
        input  out_ready
    );

    modport slave (
        input  adj_read_en, adj_read_addr,
        output adj_read_data,
        input  out_valid, out_data, out_node_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/adj_readout_fsm.sv
// Streams ADJ rows out over valid/ready once combination is done; holds each row under backpressure.
// Optional macro READOUT_RELU_EN clamps negative features to zero as rows are captured.
module adj_readout_fsm #(
    parameter int NUM_OF_NODES    = 6,
    parameter int NUM_OF_FEATURES = 3,
    parameter int FEATURE_WIDTH   = 16,
    parameter int ADDRESS_WIDTH   = (NUM_OF_NODES > 1) ? $clog2(NUM_OF_NODES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          done_comb,
    output logic          done_readout,
    adj_readout_if.master bus
);
    localparam int ROW_W = NUM_OF_FEATURES * FEATURE_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_NODE = ADDRESS_WIDTH'(NUM_OF_NODES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE_ADDR  = ADDRESS_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                   state_r, state_s;
    logic [ADDRESS_WIDTH-1:0] cnt_r, cnt_s;
    logic [ROW_W-1:0]         data_r, data_s;
    logic [ADDRESS_WIDTH-1:0] idx_r, idx_s;
    logic                     read_en_r;
    logic                     valid_r;
    logic                     last_r;
    logic                     done_r;

`ifdef READOUT_RELU_EN
    // Zero every feature whose sign bit is set; others pass through.
    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] res;
        res = row;
        for (int f = 0; f < NUM_OF_FEATURES; f++) begin
            if (row[f*FEATURE_WIDTH + FEATURE_WIDTH - 1]) begin
                res[f*FEATURE_WIDTH +: FEATURE_WIDTH] = {FEATURE_WIDTH{1'b0}};
            end else begin
                res[f*FEATURE_WIDTH +: FEATURE_WIDTH] = row[f*FEATURE_WIDTH +: FEATURE_WIDTH];
            end
        end
        return res;
    endfunction
`endif

    // Next-state, row counter and capture-register update.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {ADDRESS_WIDTH{1'b0}};
                if (done_comb) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
`ifdef READOUT_RELU_EN
                data_s  = relu_row(bus.adj_read_data);
`else
                data_s  = bus.adj_read_data;
`endif
                idx_s   = cnt_r;
                state_s = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (bus.out_ready) begin
                    if (cnt_r == LAST_NODE) begin
                        state_s = ST_DONE;
                    end else begin
                        cnt_s   = cnt_r + ONE_ADDR;
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {ADDRESS_WIDTH{1'b0}};
            end
        endcase
    end

    // State, counter, row registers; strobes are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {ADDRESS_WIDTH{1'b0}};
            data_r    <= {ROW_W{1'b0}};
            idx_r     <= {ADDRESS_WIDTH{1'b0}};
            read_en_r <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            data_r    <= data_s;
            idx_r     <= idx_s;
            read_en_r <= (state_s == ST_READ);
            valid_r   <= (state_s == ST_PRESENT);
            last_r    <= (state_s == ST_PRESENT) && (cnt_s == LAST_NODE);
            done_r    <= (state_s == ST_DONE);
        end
    end

    assign bus.adj_read_en    = read_en_r;
    assign bus.adj_read_addr  = cnt_r;
    assign bus.out_valid      = valid_r;
    assign bus.out_data       = data_r;
    assign bus.out_node_index = idx_r;
    assign bus.out_last       = last_r;
    assign done_readout       = done_r;
endmodule

// File: tb/tb_adj_readout_fsm.sv
// Self-checking bench for adj_readout_fsm: memory model plus an expected-row stream derived from the ADJ contents.
module tb_adj_readout_fsm;
    localparam int N     = 6;
    localparam int NF    = 3;
    localparam int FW    = 16;
    localparam int AW    = $clog2(N);
    localparam int ROW_W = NF * FW;

    logic clk;
    logic reset;
    logic done_comb;
    logic done_readout;
    int   vectors;
    int   miscompares;

    logic [ROW_W-1:0] mem [N];

    adj_readout_if #(.NUM_OF_NODES(N), .NUM_OF_FEATURES(NF), .FEATURE_WIDTH(FW), .ADDRESS_WIDTH(AW)) bus ();

    adj_readout_fsm #(.NUM_OF_NODES(N), .NUM_OF_FEATURES(NF), .FEATURE_WIDTH(FW), .ADDRESS_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .done_comb    (done_comb),
        .done_readout (done_readout),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADJ memory: data is only meaningful the cycle after a read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (bus.adj_read_en) bus.adj_read_data <= mem[bus.adj_read_addr];
        else                 bus.adj_read_data <= ROW_W'({$urandom, $urandom});
    end

    function automatic logic [ROW_W-1:0] exp_row(input int n);
        logic [ROW_W-1:0] r;
        logic signed [FW-1:0] f;
        r = mem[n];
`ifdef READOUT_RELU_EN
        for (int k = 0; k < NF; k++) begin
            f = r[k*FW +: FW];
            if (f < 0) r[k*FW +: FW] = '0;
        end
`endif
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = ROW_W'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; done_comb = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; done_comb = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.adj_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_read_en: got %b expected 0", bus.adj_read_en); end
        vectors++; if (bus.adj_read_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0h expected 0", bus.adj_read_addr); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        vectors++; if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b expected 0", bus.out_last); end
        vectors++; if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_data: got %0h expected 0", bus.out_data); end
        vectors++; if (bus.out_node_index !== '0) begin miscompares++; $display("FAIL reset_index: got %0h expected 0", bus.out_node_index); end
        vectors++; if (done_readout !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done_readout); end
        reset = 1'b0; done_comb = 1'b0; bus.out_ready = 1'b0;
    endtask

    // Starts a readout from IDLE and checks every row, the hold rule, read gating and completion time.
    task automatic run_stream(input string tag, input int ready_pct, input int stall_node, input int stall_len);
        int exp_node, c, stalls, reads, stall_left, first_valid;
        bit prev_valid, prev_fire, fire, finished;
        logic [ROW_W-1:0] prev_data;
        logic [AW-1:0] prev_idx;
        exp_node = 0; c = 0; stalls = 0; reads = 0; stall_left = stall_len; first_valid = -1;
        prev_valid = 1'b0; prev_fire = 1'b0; finished = 1'b0; prev_data = '0; prev_idx = '0;
        @(negedge clk);
        done_comb = 1'b1; bus.out_ready = 1'b1;
        while (!finished && c < 4000) begin
            @(negedge clk);
            c++;
            done_comb = 1'b0;
            if (bus.adj_read_en) begin
                reads++;
                vectors++;
                if (bus.out_valid || bus.adj_read_addr !== AW'(exp_node)) begin
                    miscompares++;
                    $display("FAIL %s read_issue: got addr %0d valid %b expected addr %0d valid 0", tag, bus.adj_read_addr, bus.out_valid, exp_node);
                end
            end
            if (prev_valid && !prev_fire) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_node_index !== prev_idx) begin
                    miscompares++;
                    $display("FAIL %s hold: got valid %b data %0h idx %0d expected valid 1 data %0h idx %0d", tag, bus.out_valid, bus.out_data, bus.out_node_index, prev_data, prev_idx);
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (first_valid < 0) begin
                    first_valid = c;
                    vectors++;
                    if (c != 3) begin miscompares++; $display("FAIL %s first_valid_cycle: got %0d expected 3", tag, c); end
                end
                vectors++;
                if (exp_node >= N) begin
                    miscompares++;
                    $display("FAIL %s extra_row: got idx %0d expected no row", tag, bus.out_node_index);
                end else if (bus.out_node_index !== AW'(exp_node) || bus.out_data !== exp_row(exp_node) || bus.out_last !== (exp_node == N-1)) begin
                    miscompares++;
                    $display("FAIL %s row: got idx %0d data %0h last %b expected idx %0d data %0h last %b", tag, bus.out_node_index, bus.out_data, bus.out_last, exp_node, exp_row(exp_node), (exp_node == N-1));
                end
            end else begin
                vectors++;
                if (bus.out_last !== 1'b0) begin miscompares++; $display("FAIL %s last_without_valid: got %b expected 0", tag, bus.out_last); end
            end
            if (done_readout === 1'b1) begin
                finished = 1'b1;
                vectors++; if (c != 3*N + 1 + stalls) begin miscompares++; $display("FAIL %s done_time: got %0d expected %0d", tag, c, 3*N + 1 + stalls); end
                vectors++; if (exp_node != N || reads != N) begin miscompares++; $display("FAIL %s done_counts: got rows %0d reads %0d expected %0d", tag, exp_node, reads, N); end
                vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL %s done_valid: got %b expected 0", tag, bus.out_valid); end
            end
            if (bus.out_valid === 1'b1 && bus.out_node_index == AW'(stall_node) && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = ($urandom_range(1, 100) <= ready_pct);
            end
            fire = (bus.out_valid === 1'b1) && bus.out_ready;
            if (bus.out_valid === 1'b1 && !bus.out_ready) stalls++;
            if (fire) exp_node++;
            prev_valid = (bus.out_valid === 1'b1);
            prev_fire  = fire;
            prev_data  = bus.out_data;
            prev_idx   = bus.out_node_index;
        end
        if (!finished) begin
            miscompares++;
            $display("FAIL %s timeout: got no done_readout after %0d cycles expected done", tag, c);
        end
    endtask

    task automatic test_basic_stream();
        for (int i = 0; i < N; i++) mem[i] = {FW'(-i), FW'(2*i), FW'(i+1)};
        do_reset();
        run_stream("basic", 100, -1, 0);
    endtask

    task automatic test_backpressure();
        fill_random();
        do_reset();
        run_stream("backpressure", 100, 2, 5);
    endtask

    task automatic test_relu();
        fill_random();
        mem[3] = {16'h8000, 16'd7, 16'hFFFB};
        do_reset();
        run_stream("relu", 100, -1, 0);
    endtask

    task automatic test_reset_midstream();
        bit hit;
        fill_random();
        do_reset();
        @(negedge clk);
        done_comb = 1'b1; bus.out_ready = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            done_comb = 1'b0;
            if (bus.out_valid === 1'b1 && bus.out_node_index == AW'(4)) begin
                reset = 1'b1;
                hit = 1'b1;
            end
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL midreset_reach: got no node 4 expected node 4 presented"); end
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({bus.adj_read_en, bus.out_valid, bus.out_last, done_readout} !== 4'b0000 || bus.out_data !== '0 || bus.out_node_index !== '0 || bus.adj_read_addr !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got en %b valid %b last %b done %b data %0h idx %0d addr %0d expected all 0",
                     bus.adj_read_en, bus.out_valid, bus.out_last, done_readout, bus.out_data, bus.out_node_index, bus.adj_read_addr);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.adj_read_en !== 1'b0 || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_idle: got en %b valid %b expected 0 0", bus.adj_read_en, bus.out_valid);
            end
        end
        run_stream("restart", 100, -1, 0);
    endtask

    task automatic test_idle_done_guard();
        bit bad;
        do_reset();
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.adj_read_en !== 1'b0 || bus.out_valid !== 1'b0 || done_readout !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin miscompares++; $display("FAIL idle_guard: got activity without done_comb expected none"); end
        fill_random();
        run_stream("guard", 70, -1, 0);
        for (int k = 0; k < 20; k++) begin
            done_comb     = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if ({done_readout, bus.out_valid, bus.adj_read_en} !== 3'b100) begin
                miscompares++;
                $display("FAIL done_guard: got done %b valid %b en %b expected 1 0 0", done_readout, bus.out_valid, bus.adj_read_en);
            end
        end
        done_comb = 1'b0;
    endtask

    task automatic test_random_stream();
        for (int r = 0; r < 4; r++) begin
            fill_random();
            do_reset();
            run_stream("random", 30 + 20 * r, $urandom_range(0, N-1), $urandom_range(0, 6));
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; done_comb = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        test_reset();
        test_idle_done_guard();
        test_basic_stream();
        test_backpressure();
        test_relu();
        test_reset_midstream();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
